// File: rtl/bennett_clock_arbiter.sv
// Bennett clock arbiter: lends the single Bennett clock generator to one of
// NREQ requesters at a time for a burst of full Bennett cycles, keeps the
// generator in reset between bursts, and watches for a stalled generator.
module bennett_clock_arbiter #(
  parameter int NREQ    = 4,
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BURST_W-1:0] burst,
  input  logic                    clear_err,
  input  logic                    gen_instflag,
  output logic                    gen_reset,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [BURST_W-1:0]      beats_left,
  output logic                    timeout_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, COOL, FAULT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   owner_next;
  logic [IDX_W-1:0]   win_idx;
  logic               found;
  logic [WD_W-1:0]    wdog;
  logic [BURST_W-1:0] win_burst;
  logic               last_beat;
  logic [BURST_W-1:0] burst_field [NREQ];

  // Split the packed burst bus into per-requester length fields.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_field
    assign burst_field[gi] = burst[gi*BURST_W +: BURST_W];
  end

  // Round-robin pick: first requester at or above rr_ptr, wrapping around.
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    logic [IDX_W-1:0] scan_idx;
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign win_burst  = burst_field[win_idx];
  assign owner_next = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;

  // The final instFlag must re-assert gen_reset in the same cycle so the
  // generator never starts another RAMP_UP; this path is combinational.
  assign last_beat = (state == RUN) & gen_instflag & (beats_left == BURST_W'(1));
  assign gen_reset = (state != RUN) | last_beat;
  assign busy      = (state == RUN);

  // Arbiter FSM with registered grant/done/beat/fault outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      done        <= '0;
      beats_left  <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      owner       <= '0;
      wdog        <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= NREQ'(1) << win_idx;
            owner      <= win_idx;
            beats_left <= (win_burst == '0) ? BURST_W'(1) : win_burst;
            wdog       <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (last_beat) begin
            done       <= grant;
            grant      <= '0;
            beats_left <= '0;
            rr_ptr     <= owner_next;
            state      <= COOL;
          end else if (gen_instflag) begin
            beats_left <= beats_left - 1'b1;
            wdog       <= '0;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            // Stalled generator: drop the grant without a done pulse and
            // skip the faulted requester on the next arbitration.
            timeout_err <= 1'b1;
            grant       <= '0;
            rr_ptr      <= owner_next;
            state       <= FAULT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        COOL: begin
          state <= IDLE;
        end
        FAULT: begin
          if (clear_err) begin
            timeout_err <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bennett_clock_arbiter.sv
// Directed testbench for bennett_clock_arbiter with a behavioural stub of
// the Bennett generator (WIDTH=11, one instFlag every 2*WIDTH+1 clks).
module tb_bennett_clock_arbiter;
  localparam int NREQ    = 4;
  localparam int BURST_W = 4;
  localparam int TIMEOUT = 64;
  localparam int WIDTH   = 11;
  localparam int PERIOD  = 2 * WIDTH + 1;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [NREQ-1:0]         req = '0;
  logic [NREQ*BURST_W-1:0] burst = '0;
  logic                    clear_err = 1'b0;
  logic                    gen_instflag = 1'b0;
  logic                    gen_reset;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         done;
  logic                    busy;
  logic [BURST_W-1:0]      beats_left;
  logic                    timeout_err;

  int checks = 0;
  int failures = 0;
  bit gen_en = 1'b1;
  int gen_cnt = 0;

  bennett_clock_arbiter #(.NREQ(NREQ), .BURST_W(BURST_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .burst(burst), .clear_err(clear_err),
    .gen_instflag(gen_instflag), .gen_reset(gen_reset), .grant(grant), .done(done),
    .busy(busy), .beats_left(beats_left), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Generator stub: counts while released, pulses instFlag for one clk.
  initial forever begin
    @(posedge clk);
    #1;
    if (gen_instflag) begin
      gen_instflag = 1'b0;
      gen_cnt = 0;
    end else if (gen_reset) begin
      gen_cnt = 0;
    end else begin
      gen_cnt++;
      if (gen_en && gen_cnt >= PERIOD - 1) gen_instflag = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_flag(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      if (gen_instflag === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req = '0; burst = '0; clear_err = 1'b0; gen_en = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++; if (beats_left !== 4'd0) begin failures++; $display("FAIL reset_beats got=%0d exp=0", beats_left); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
    checks++; if (gen_reset !== 1'b1) begin failures++; $display("FAIL reset_genrst got=%b exp=1", gen_reset); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    tick();
    $display("reset: grant=%b gen_reset=%b", grant, gen_reset);
  endtask

  task automatic test_single_beat();
    bit ok;
    req = 4'b0001; burst = 16'h1111;
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", grant); end
    checks++; if (beats_left !== 4'd1) begin failures++; $display("FAIL single_beats got=%0d exp=1", beats_left); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    req = 4'b0000;
    wait_flag(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_flag got=none exp=instflag"); end
    checks++; if (gen_reset !== 1'b1) begin failures++; $display("FAIL single_genrst_same got=%b exp=1", gen_reset); end
    tick();
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL single_done got=%b exp=0001", done); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", grant); end
    tick();
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_done_pulse got=%b exp=0000", done); end
    $display("single: req=0001 burst=1 done seen");
  endtask

  task automatic test_multi_beat();
    bit ok;
    int clks;
    apply_reset();
    req = 4'b0001; burst = 16'h0003;
    tick();
    checks++; if (beats_left !== 4'd3) begin failures++; $display("FAIL multi_beats3 got=%0d exp=3", beats_left); end
    req = 4'b0000; burst = 16'h0005;
    clks = 0;
    for (int b = 3; b >= 1; b--) begin
      wait_flag(ok);
      checks++; if (!ok) begin failures++; $display("FAIL multi_flag%0d got=none exp=instflag", b); end
      checks++; if (gen_reset !== (b == 1)) begin failures++; $display("FAIL multi_genrst%0d got=%b exp=%b", b, gen_reset, (b == 1)); end
      tick();
      if (b > 1) begin
        checks++; if (beats_left !== 4'(b - 1)) begin failures++; $display("FAIL multi_beats got=%0d exp=%0d", beats_left, b - 1); end
      end
    end
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL multi_done got=%b exp=0001", done); end
    $display("multi: 3 beats done=%b", done);
  endtask

  task automatic test_round_robin();
    bit ok;
    int idle;
    logic [NREQ-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    apply_reset();
    req = 4'b1111; burst = 16'h1111;
    idle = 0;
    for (int n = 0; n < 5; n++) begin
      for (int w = 0; w < 10; w++) begin
        tick();
        if (grant !== 4'b0000) break;
        if (gen_reset) idle++;
      end
      checks++; if (grant !== exp_g[n]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", n, grant, exp_g[n]); end
      if (n > 0) begin
        checks++; if (idle < 2) begin failures++; $display("FAIL rr_gap%0d got=%0d exp>=2", n, idle); end
      end
      wait_flag(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_flag%0d got=none exp=instflag", n); end
      tick();
      checks++; if (done !== exp_g[n]) begin failures++; $display("FAIL rr_done%0d got=%b exp=%b", n, done, exp_g[n]); end
      idle = (gen_reset && grant == 4'b0000) ? 1 : 0;
      $display("rr: grant %0d = %b done", n, exp_g[n]);
    end
    req = 4'b0000;
  endtask

  task automatic test_zero_burst();
    bit ok;
    apply_reset();
    req = 4'b0100; burst = 16'h0000;
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL zero_grant got=%b exp=0100", grant); end
    checks++; if (beats_left !== 4'd1) begin failures++; $display("FAIL zero_beats got=%0d exp=1", beats_left); end
    req = 4'b0000;
    wait_flag(ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_flag got=none exp=instflag"); end
    tick();
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL zero_done got=%b exp=0100", done); end
    $display("zero: burst2=0 done=%b", done);
  endtask

  task automatic test_timeout();
    int n;
    bit done_seen;
    apply_reset();
    gen_en = 1'b0;
    req = 4'b0010; burst = 16'h0020;
    tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL to_grant got=%b exp=0010", grant); end
    n = 0; done_seen = 1'b0;
    while (busy && n < 200) begin
      n++;
      if (done !== 4'b0000) done_seen = 1'b1;
      tick();
    end
    checks++; if (n != TIMEOUT) begin failures++; $display("FAIL to_run_clks got=%0d exp=%0d", n, TIMEOUT); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL to_grant_drop got=%b exp=0000", grant); end
    checks++; if (gen_reset !== 1'b1) begin failures++; $display("FAIL to_genrst got=%b exp=1", gen_reset); end
    checks++; if (done_seen || done !== 4'b0000) begin failures++; $display("FAIL to_nodone got=%b exp=0000", done); end
    checks++; if (beats_left !== 4'd2) begin failures++; $display("FAIL to_beats_frozen got=%0d exp=2", beats_left); end
    req = 4'b1111;
    repeat (3) tick();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL to_ignore_req got=%b exp=0000", grant); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
    gen_en = 1'b1;
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL to_next_winner got=%b exp=0100", grant); end
    req = 4'b0000;
    $display("timeout: fault after %0d clks, next grant=%b", n, grant);
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req = 4'b0001; burst = 16'h0002;
    tick();
    checks++; if (beats_left !== 4'd2) begin failures++; $display("FAIL mid_beats got=%0d exp=2", beats_left); end
    req = 4'b0000;
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL mid_grant got=%b exp=0000", grant); end
    checks++; if (gen_reset !== 1'b1) begin failures++; $display("FAIL mid_genrst got=%b exp=1", gen_reset); end
    checks++; if (beats_left !== 4'd0) begin failures++; $display("FAIL mid_beats0 got=%0d exp=0", beats_left); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL mid_done got=%b exp=0000", done); end
    repeat (2) tick();
    reset_n = 1'b1;
    req = 4'b0011; burst = 16'h0011;
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL mid_restart got=%b exp=0001", grant); end
    req = 4'b0000;
    $display("reset_mid: restart grant=%b", grant);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_round_robin();
    test_zero_burst();
    test_timeout();
    test_reset_mid_burst();
    apply_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
